// File: rtl/aes_pkg.sv
// aes_pkg: shared GF(2^8) helpers, FSM states and column index type for the AES mix stages
package aes_pkg;
  localparam logic [7:0] AES_POLY = 8'h1b;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef logic [1:0] col_t;
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
  endfunction
endpackage

// File: rtl/mix_single_column.sv
// mix_single_column: combinational forward MixColumns of one 4-byte column (a[0] = row 0)
module mix_single_column
  import aes_pkg::*;
(
  input  logic [3:0][7:0] a,
  output logic [3:0][7:0] r
);
  logic [3:0][7:0] d;
  for (genvar i = 0; i < 4; i++) begin : g_dbl
    assign d[i] = xtime(a[i]);
  end
  // 3x is folded in as 2x ^ x
  assign r[0] = d[0] ^ d[1] ^ a[1] ^ a[2] ^ a[3];
  assign r[1] = a[0] ^ d[1] ^ d[2] ^ a[2] ^ a[3];
  assign r[2] = a[0] ^ a[1] ^ d[2] ^ d[3] ^ a[3];
  assign r[3] = d[0] ^ a[0] ^ a[1] ^ a[2] ^ d[3];
endmodule

// File: rtl/mix_column_fwd.sv
// mix_column_fwd: forward AES MixColumns, one column per clock through a shared mixer, valid/ready handshake
module mix_column_fwd
  import aes_pkg::*;
(
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] sm0, sm1, sm2, sm3, sm4, sm5, sm6, sm7,
  input  logic [7:0] sm8, sm9, sm10, sm11, sm12, sm13, sm14, sm15,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] mixed0, mixed1, mixed2, mixed3, mixed4, mixed5, mixed6, mixed7,
  output logic [7:0] mixed8, mixed9, mixed10, mixed11, mixed12, mixed13, mixed14, mixed15,
  output logic       busy
);
  state_t state;
  col_t col;
  logic [15:0][7:0] work, res;
  logic [3:0][7:0] col_in, col_out;
  assign col_in = work[{col, 2'b00} +: 4];
  mix_single_column u_mix (.a(col_in), .r(col_out));
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      state     <= IDLE;
      col       <= '0;
      work      <= '0;
      res       <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            work     <= {sm15, sm14, sm13, sm12, sm11, sm10, sm9, sm8,
                         sm7, sm6, sm5, sm4, sm3, sm2, sm1, sm0};
            col      <= '0;
            state    <= BUSY;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        BUSY: begin
          res[{col, 2'b00} +: 4] <= col_out;
          col <= col + 2'd1;
          if (col == 2'd3) begin
            state     <= DONE;
            out_valid <= 1'b1;
            busy      <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign {mixed15, mixed14, mixed13, mixed12, mixed11, mixed10, mixed9, mixed8,
          mixed7, mixed6, mixed5, mixed4, mixed3, mixed2, mixed1, mixed0} = res;
endmodule

// File: tb/tb_mix_column_fwd.sv
// tb_mix_column_fwd: randomized and directed checks of mix_column_fwd against a GF(2^8) matrix model
module tb_mix_column_fwd;
  typedef logic [15:0][7:0] st_t;
  logic sys_clk = 1'b0, sys_rst = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, busy;
  st_t sm = '0;
  logic [7:0] mx [16];
  int total = 0, bad = 0;

  always #5 sys_clk = ~sys_clk;

  mix_column_fwd dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .in_valid(in_valid), .in_ready(in_ready),
    .sm0(sm[0]), .sm1(sm[1]), .sm2(sm[2]), .sm3(sm[3]), .sm4(sm[4]), .sm5(sm[5]),
    .sm6(sm[6]), .sm7(sm[7]), .sm8(sm[8]), .sm9(sm[9]), .sm10(sm[10]), .sm11(sm[11]),
    .sm12(sm[12]), .sm13(sm[13]), .sm14(sm[14]), .sm15(sm[15]),
    .out_valid(out_valid), .out_ready(out_ready),
    .mixed0(mx[0]), .mixed1(mx[1]), .mixed2(mx[2]), .mixed3(mx[3]), .mixed4(mx[4]),
    .mixed5(mx[5]), .mixed6(mx[6]), .mixed7(mx[7]), .mixed8(mx[8]), .mixed9(mx[9]),
    .mixed10(mx[10]), .mixed11(mx[11]), .mixed12(mx[12]), .mixed13(mx[13]),
    .mixed14(mx[14]), .mixed15(mx[15]), .busy(busy)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
    end
    return p;
  endfunction

  // circulant matrix rows are rotations of {2,3,1,1}
  function automatic st_t model(input st_t s);
    logic [7:0] coef [4] = '{8'h02, 8'h03, 8'h01, 8'h01};
    st_t o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        for (int k = 0; k < 4; k++)
          o[4*c+r] ^= gmul(coef[(k - r + 4) % 4], s[4*c+k]);
    return o;
  endfunction

  function automatic st_t outs();
    st_t o;
    for (int i = 0; i < 16; i++) o[i] = mx[i];
    return o;
  endfunction

  function automatic st_t rnd_state();
    st_t s;
    for (int i = 0; i < 16; i++) s[i] = 8'($urandom);
    return s;
  endfunction

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // accept a state, wait for out_valid, compare; leaves the block in DONE
  task automatic send(input string name, input st_t s, input st_t exp);
    int n = 0;
    sm = s;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin step(); n++; end
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin step(); n++; end
    total++;
    if (n != 4) begin bad++; $display("FAIL %s latency got=%0d want=4", name, n); end
    total++;
    if (outs() !== exp) begin bad++; $display("FAIL %s data got=%h want=%h", name, outs(), exp); end
  endtask

  task automatic release_done();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin bad++; $display("FAIL release got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready); end
  endtask

  st_t fips_in, fips_out;

  task automatic test_reset();
    sys_rst = 1'b0;
    step(); step();
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || outs() !== '0)
      begin bad++; $display("FAIL reset got ir=%b ov=%b busy=%b mixed=%h want 0", in_ready, out_valid, busy, outs()); end
    sys_rst = 1'b1;
    step();
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_fips();
    send("fips", fips_in, fips_out);
    release_done();
  endtask

  task automatic test_full();
    st_t s = {8'h4c, 8'h31, 8'h26, 8'h2d, 8'hd5, 8'hd4, 8'hd4, 8'hd4,
              8'hc6, 8'hc6, 8'hc6, 8'hc6, 8'h5c, 8'h22, 8'h0a, 8'hf2};
    st_t e = {8'hf8, 8'hbd, 8'h7e, 8'h4d, 8'hd6, 8'hd7, 8'hd5, 8'hd5,
              8'hc6, 8'hc6, 8'hc6, 8'hc6, 8'h9d, 8'h58, 8'hdc, 8'h9f};
    send("full", s, e);
    release_done();
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      st_t s = rnd_state();
      send("random", s, model(s));
      release_done();
    end
  endtask

  task automatic test_backpressure();
    st_t s = rnd_state();
    st_t e = model(s);
    logic ok = 1'b1;
    send("bp", s, e);
    for (int i = 0; i < 10; i++) begin
      step();
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || outs() !== e) ok = 1'b0;
    end
    total++;
    if (!ok) begin bad++; $display("FAIL backpressure_hold got ov=%b ir=%b mixed=%h want ov=1 ir=0 mixed=%h", out_valid, in_ready, outs(), e); end
    release_done();
  endtask

  task automatic test_busy_ignore();
    st_t s = rnd_state();
    st_t e = model(s);
    int n = 0;
    sm = s;
    in_valid = 1'b1;
    step();
    while (!out_valid && n < 20) begin
      sm = rnd_state();
      in_valid = ~in_valid;
      step();
      n++;
    end
    in_valid = 1'b0;
    total++;
    if (outs() !== e || n != 4) begin bad++; $display("FAIL busy_ignore got=%h lat=%0d want=%h lat=4", outs(), n, e); end
    release_done();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL busy_ignore_no_capture ov got=%b want=0", out_valid); end
  endtask

  task automatic test_reset_mid();
    sm = rnd_state();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    sys_rst = 1'b0;
    step();
    total++;
    if (out_valid !== 1'b0 || outs() !== '0 || in_ready !== 1'b0 || busy !== 1'b0)
      begin bad++; $display("FAIL reset_mid got ov=%b ir=%b busy=%b mixed=%h want all 0", out_valid, in_ready, busy, outs()); end
    sys_rst = 1'b1;
    step();
    send("reset_mid_fips", fips_in, fips_out);
    release_done();
  endtask

  task automatic test_back_to_back();
    st_t q [$];
    st_t s;
    int accepted = 0, got = 0, last = -1, cyc = 0;
    s = rnd_state();
    sm = s;
    in_valid = 1'b1;
    out_ready = 1'b1;
    while (got < 3 && cyc < 60) begin
      logic acc = in_valid && in_ready;
      if (out_valid) begin
        total++;
        if (q.size() == 0 || outs() !== q[0]) begin bad++; $display("FAIL b2b_data got=%h", outs()); end
        if (q.size() != 0) void'(q.pop_front());
        if (last >= 0) begin
          total++;
          if (cyc - last != 6) begin bad++; $display("FAIL b2b_spacing got=%0d want=6", cyc - last); end
        end
        last = cyc;
        got++;
      end
      if (acc) begin q.push_back(model(s)); accepted++; end
      step();
      cyc++;
      if (acc) begin
        s = rnd_state();
        sm = s;
        if (accepted == 3) in_valid = 1'b0;
      end
    end
    out_ready = 1'b0;
    in_valid = 1'b0;
    total++;
    if (got != 3) begin bad++; $display("FAIL b2b_count got=%0d want=3", got); end
  endtask

  initial begin
    fips_in = {{12{8'h01}}, 8'h45, 8'h53, 8'h13, 8'hdb};
    fips_out = {{12{8'h01}}, 8'hbc, 8'ha1, 8'h4d, 8'h8e};
    test_reset();
    test_fips();
    test_full();
    test_random();
    test_backpressure();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
